// File: rtl/serial_op_pkg.sv
// rtl/serial_op_pkg.sv - shared types and width helpers for the serial operand engine
//
// Purpose: FSM state and op-code enums plus helpers that derive the beat
// count and beat-counter width from the operand and beat widths.
// Ports: none (package).
package serial_op_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_MASK_OR     = 3'd0,
    OP_XOR_ADD     = 3'd1,
    OP_ABSDIFF_XOR = 3'd2,
    OP_MIN_SPLICE  = 3'd3,
    OP_MAX_ADD     = 3'd4,
    OP_SATADD_AND  = 3'd5,
    OP_AVG_OR      = 3'd6,
    OP_ROTL_XOR    = 3'd7
  } op_t;

  localparam int N_DEFAULT = 64;
  localparam int W_DEFAULT = 4;

  // Number of W-bit beats in an N-bit word.
  function automatic int beats_of(input int n, input int w);
    return n / w;
  endfunction

  // Beat counter width; at least one bit so the counter is never zero-width.
  function automatic int cw_of(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/serial_op_alu.sv
// rtl/serial_op_alu.sv - combinational accumulate-operation unit
//
// Purpose: computes the next accumulator value y = f(op, A, B, C), mod 2^N.
// Ports:
//   op_code_i  in  3  operation select
//   a_i, b_i   in  N  operands
//   c_i        in  N  current accumulator
//   y_o        out N  next accumulator value
module serial_op_alu
  import serial_op_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic [2:0]   op_code_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [N-1:0] c_i,
  output logic [N-1:0] y_o
);

  logic         a_lt_b;
  logic [N-1:0] max_ab;
  logic [N-1:0] abs_diff;
  logic [N:0]   sum_ab;
  logic [N-1:0] sat_ab;

  assign a_lt_b   = a_i < b_i;
  assign max_ab   = a_lt_b ? b_i : a_i;
  assign abs_diff = a_lt_b ? (b_i - a_i) : (a_i - b_i);
  // One extra bit keeps the carry so the sum can saturate instead of wrap.
  assign sum_ab   = {1'b0, a_i} + {1'b0, b_i};
  assign sat_ab   = sum_ab[N] ? '1 : sum_ab[N-1:0];

  always_comb begin
    y_o = '0;
    case (op_t'(op_code_i))
      OP_MASK_OR:     y_o = (a_i & b_i) | c_i;
      OP_XOR_ADD:     y_o = (a_i ^ b_i) + c_i;
      OP_ABSDIFF_XOR: y_o = abs_diff ^ c_i;
      // Keep the accumulator's upper half, replace the lower half with min(A,B).
      OP_MIN_SPLICE:  y_o = {c_i[N-1:N/2], (a_lt_b ? a_i[N/2-1:0] : b_i[N/2-1:0])};
      OP_MAX_ADD:     y_o = max_ab + {c_i[N-2:0], 1'b0};
      OP_SATADD_AND:  y_o = sat_ab & c_i;
      // Overflow-free floor average of A and B.
      OP_AVG_OR:      y_o = ((a_i & b_i) + ((a_i ^ b_i) >> 1)) | c_i;
      OP_ROTL_XOR:    y_o = {a_i[N-2:0], a_i[N-1]} ^ b_i ^ c_i;
      default:        y_o = '0;
    endcase
  end

endmodule

// File: rtl/serial_op_engine.sv
// rtl/serial_op_engine.sv - beat-serial operand load, op sequence, result drain
//
// Purpose: loads two N-bit operands as W-bit beats (LSB first), applies a
// host-driven sequence of accumulate ops, then streams the N-bit result out.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   start, abort            begin transaction (IDLE only) / return to IDLE
//   in_valid/in_ready       operand beat handshake, a_in/b_in beats
//   op_valid/op_ready       op command handshake, op_code/op_last
//   out_valid/out_ready     result beat handshake, out_data/out_last
//   busy, state_o           status
module serial_op_engine
  import serial_op_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [2:0]   op_code,
  input  logic         op_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic [1:0]   state_o
);

  localparam int BEATS = beats_of(N, W);
  localparam int CW    = cw_of(BEATS);

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, b_q, acc_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  alu_y;
  logic          cnt_last;
  logic [W-1:0]  beat_sel;

  assign cnt_last = (cnt_q == CW'(BEATS - 1));

  serial_op_alu #(.N(N)) u_alu (
    .op_code_i (op_code),
    .a_i       (a_q),
    .b_i       (b_q),
    .c_i       (acc_q),
    .y_o       (alu_y)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every handshake.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start) state_d = ST_LOAD;
        ST_LOAD:  if (in_valid && cnt_last) state_d = ST_EXEC;
        ST_EXEC:  if (op_valid && op_last) state_d = ST_DRAIN;
        ST_DRAIN: if (out_ready && cnt_last) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath. Anything heading to (or sitting in) IDLE clears the registers,
  // which covers reset, abort and normal completion with one rule.
  // BEATS is a power of two, so cnt wraps to 0 on the last LOAD beat.
  always_ff @(posedge clk) begin
    if (!rst_n || state_d == ST_IDLE) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (in_valid) begin
            for (int i = 0; i < BEATS; i++) begin
              if (cnt_q == CW'(i)) begin
                a_q[i*W +: W] <= a_in;
                b_q[i*W +: W] <= b_in;
              end
            end
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_EXEC: begin
          if (op_valid) acc_q <= alu_y;
        end
        ST_DRAIN: begin
          if (out_ready) cnt_q <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs decode registered state and cnt only.
  always_comb begin
    beat_sel = '0;
    for (int i = 0; i < BEATS; i++) begin
      if (cnt_q == CW'(i)) beat_sel = acc_q[i*W +: W];
    end
    in_ready  = (state_q == ST_LOAD);
    op_ready  = (state_q == ST_EXEC);
    out_valid = (state_q == ST_DRAIN);
    out_last  = (state_q == ST_DRAIN) && cnt_last;
    out_data  = (state_q == ST_DRAIN) ? beat_sel : '0;
    busy      = (state_q != ST_IDLE);
    state_o   = state_q;
  end

endmodule

// File: tb/tb_serial_op_engine.sv
// tb/tb_serial_op_engine.sv - self-checking bench for serial_op_engine (N=16, W=4)
module tb_serial_op_engine;

  localparam int N = 16;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         op_valid = 1'b0;
  logic [2:0]   op_code = '0;
  logic         op_last = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready, op_ready, out_valid, out_last, busy;
  logic [W-1:0] out_data;
  logic [1:0]   state_o;

  int errors = 0;
  int checks = 0;

  logic [15:0] d_res;
  int          d_nhs;
  logic [3:0]  d_last;
  int          d_unstable;
  bit          d_tmo;

  serial_op_engine #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_code   (op_code),
    .op_last   (op_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  // Reference: each op evaluated with plain integer arithmetic on 16-bit values.
  function automatic int ref_op(input int code, input int a, input int b, input int c);
    int r;
    case (code)
      0: r = (a & b) | c;
      1: r = ((a ^ b) + c) % 65536;
      2: r = ((a > b) ? a - b : b - a) ^ c;
      3: r = (c & 'hFF00) | (((a < b) ? a : b) & 'hFF);
      4: r = (((a > b) ? a : b) + 2 * c) % 65536;
      5: r = ((a + b > 65535) ? 65535 : a + b) & c;
      6: r = ((a & b) + ((a ^ b) / 2)) | c;
      default: r = (((a * 2) % 65536) + (a / 32768)) ^ b ^ c;
    endcase
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_beats(input logic [15:0] a, input logic [15:0] b, input int first, input int n);
    for (int k = first; k < first + n; k++) begin
      in_valid = 1'b1;
      a_in = a[k*4 +: 4];
      b_in = b[k*4 +: 4];
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic send_op(input int code, input bit last);
    op_valid = 1'b1;
    op_code  = 3'(code);
    op_last  = last;
    step();
    op_valid = 1'b0;
    op_last  = 1'b0;
  endtask

  // Collects result beats; stalls out_ready for stall_cycles on beat stall_beat.
  task automatic drain(input int stall_beat, input int stall_cycles);
    int stalled;
    bit prev_stall;
    logic [4:0] prev;
    d_res = '0; d_nhs = 0; d_last = '0; d_unstable = 0; d_tmo = 1'b1;
    stalled = 0; prev_stall = 1'b0; prev = '0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      if (out_valid) begin
        if (prev_stall && {out_last, out_data} !== prev) d_unstable++;
        if (d_nhs == stall_beat && stalled < stall_cycles) begin
          out_ready = 1'b0;
          stalled++;
        end else begin
          out_ready = 1'b1;
        end
        prev_stall = !out_ready;
        prev = {out_last, out_data};
        if (out_ready && d_nhs < 4) begin
          d_res[d_nhs*4 +: 4] = out_data;
          if (out_last) d_last[d_nhs] = 1'b1;
          d_nhs++;
        end
      end else begin
        out_ready = 1'b0;
      end
      step();
      if (d_nhs == 4) begin
        d_tmo = 1'b0;
        break;
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL reset_op_ready: got %b expected 0", op_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
  endtask

  task automatic test_basic_op0();
    do_start();
    checks++; if (in_ready !== 1'b1 || state_o !== 2'd1) begin errors++; $display("FAIL basic_load_entry: in_ready=%b state=%0d expected 1/1", in_ready, state_o); end
    send_beats(16'h1234, 16'h00F0, 0, 4);
    checks++; if (op_ready !== 1'b1 || state_o !== 2'd2) begin errors++; $display("FAIL basic_exec_entry: op_ready=%b state=%0d expected 1/2", op_ready, state_o); end
    send_op(0, 1'b1);
    checks++; if (out_valid !== 1'b1 || state_o !== 2'd3) begin errors++; $display("FAIL basic_drain_entry: out_valid=%b state=%0d expected 1/3", out_valid, state_o); end
    drain(9, 0);
    checks++; if (d_res !== 16'h0030) begin errors++; $display("FAIL basic_result: got %h expected 0030", d_res); end
    checks++; if (d_last !== 4'b1000) begin errors++; $display("FAIL basic_last: got %b expected 1000", d_last); end
    checks++; if (d_tmo || state_o !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle: tmo=%0d state=%0d busy=%b expected 0/0/0", d_tmo, state_o, busy); end
  endtask

  task automatic test_op_seq();
    do_start();
    send_beats(16'h1234, 16'h00F0, 0, 4);
    send_op(1, 1'b0);
    send_op(7, 1'b1);
    checks++; if (out_data !== 4'hC) begin errors++; $display("FAIL seq_first_beat: got %h expected c", out_data); end
    drain(9, 0);
    checks++; if (d_res !== 16'h365C) begin errors++; $display("FAIL seq_result: got %h expected 365c", d_res); end
  endtask

  task automatic test_saturate();
    do_start();
    send_beats(16'hF000, 16'h2000, 0, 4);
    send_op(1, 1'b0);
    send_op(5, 1'b1);
    drain(9, 0);
    checks++; if (d_res !== 16'hD000) begin errors++; $display("FAIL saturate_result: got %h expected d000", d_res); end
  endtask

  task automatic test_backpressure();
    do_start();
    send_beats(16'h1234, 16'h00F0, 0, 4);
    send_op(1, 1'b0);
    send_op(7, 1'b1);
    drain(1, 3);
    checks++; if (d_unstable != 0) begin errors++; $display("FAIL bp_stable: got %0d changes expected 0", d_unstable); end
    checks++; if (d_nhs != 4 || d_tmo) begin errors++; $display("FAIL bp_handshakes: got %0d expected 4", d_nhs); end
    checks++; if (d_last !== 4'b1000) begin errors++; $display("FAIL bp_last: got %b expected 1000", d_last); end
    checks++; if (d_res !== 16'h365C) begin errors++; $display("FAIL bp_result: got %h expected 365c", d_res); end
    step();
    checks++; if (state_o !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_idle: state=%0d out_valid=%b expected 0/0", state_o, out_valid); end
  endtask

  task automatic test_abort();
    do_start();
    send_beats(16'hBEEF, 16'h1357, 0, 2);
    abort = 1'b1; in_valid = 1'b1; a_in = 4'h7; b_in = 4'h7;
    step();
    abort = 1'b0; in_valid = 1'b0;
    checks++; if ({state_o, in_ready, op_ready, out_valid, out_last, busy, out_data} !== 11'd0) begin
      errors++; $display("FAIL abort_outputs: state=%0d in_ready=%b busy=%b out_data=%h expected all 0", state_o, in_ready, busy, out_data);
    end
    do_start();
    send_beats(16'hBEEF, 16'h1357, 0, 2);
    rst_n = 1'b0; abort = 1'b1;
    step();
    rst_n = 1'b1; abort = 1'b0;
    checks++; if ({state_o, in_ready, op_ready, out_valid, out_last, busy, out_data} !== 11'd0) begin
      errors++; $display("FAIL rst_outputs: state=%0d in_ready=%b busy=%b out_data=%h expected all 0", state_o, in_ready, busy, out_data);
    end
    do_start();
    send_beats(16'hBEEF, 16'h1357, 0, 4);
    send_op(1, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL abort_exec_state: got %0d expected 0", state_o); end
    do_start();
    send_beats(16'h0005, 16'h0009, 0, 4);
    send_op(2, 1'b1);
    drain(9, 0);
    checks++; if (d_res !== 16'h0004) begin errors++; $display("FAIL abort_fresh_result: got %h expected 0004", d_res); end
  endtask

  task automatic test_ignored();
    logic [15:0] a, b;
    a = 16'hA5C3; b = 16'h3C5A;
    start = 1'b1; in_valid = 1'b1; a_in = 4'hF; b_in = 4'hF;
    step();
    start = 1'b0; in_valid = 1'b0;
    send_beats(a, b, 0, 2);
    op_valid = 1'b1; op_code = 3'd0; op_last = 1'b1; out_ready = 1'b1;
    step();
    op_valid = 1'b0; op_last = 1'b0; out_ready = 1'b0;
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL ign_op_in_load: state=%0d expected 1", state_o); end
    send_beats(a, b, 2, 1);
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL ign_beat_count: state=%0d expected 1 after 3 beats", state_o); end
    send_beats(a, b, 3, 1);
    in_valid = 1'b1; a_in = 4'h9; b_in = 4'h6; start = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0; start = 1'b0; out_ready = 1'b0;
    checks++; if (state_o !== 2'd2 || out_data !== 4'h0) begin errors++; $display("FAIL ign_in_exec: state=%0d out_data=%h expected 2/0", state_o, out_data); end
    send_op(6, 1'b1);
    drain(9, 0);
    checks++; if (d_res !== 16'(ref_op(6, int'(a), int'(b), 0))) begin
      errors++; $display("FAIL ign_result: got %h expected %h", d_res, 16'(ref_op(6, int'(a), int'(b), 0)));
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      int a, b, acc, nops, code;
      a = int'($urandom_range(0, 65535));
      b = int'($urandom_range(0, 65535));
      nops = int'($urandom_range(1, 8));
      acc = 0;
      do_start();
      send_beats(16'(a), 16'(b), 0, 4);
      for (int j = 0; j < nops; j++) begin
        if ($urandom_range(0, 2) == 0) step();
        code = int'($urandom_range(0, 7));
        acc = ref_op(code, a, b, acc);
        send_op(code, j == nops - 1);
      end
      drain(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
      checks++; if (d_res !== 16'(acc) || d_tmo) begin
        errors++; $display("FAIL rand_result it=%0d: got %h expected %h (a=%h b=%h ops=%0d)", it, d_res, 16'(acc), 16'(a), 16'(b), nops);
      end
      checks++; if (d_last !== 4'b1000 || state_o !== 2'd0) begin
        errors++; $display("FAIL rand_last it=%0d: last=%b state=%0d expected 1000/0", it, d_last, state_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_op0();
    test_op_seq();
    test_saturate();
    test_backpressure();
    test_abort();
    test_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
